req_priority_encoder_8to3: RTL and testbench

//   Registered 74LS148-style 8-to-3 priority encoder; inverse of the 3-to-8 decoder stage.

---
 rtl/req_priority_encoder_8to3.sv | 111 +++++++++++
 tb/tb_req_priority_encoder_8to3.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/req_priority_encoder_8to3.sv
// Registered 74LS148-style 8-to-3 priority encoder with edge-captured, sticky
// active-low requests and a valid/ack handshake toward the consumer.
module req_priority_encoder_8to3 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EI_n,
  input  logic [7:0] I_n,
  input  logic       ack,
  output logic [2:0] A_n,
  output logic       GS_n,
  output logic       valid,
  output logic       EO_n,
  output logic [7:0] pending
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t                        state_r, state_next_s;
  logic [SYNC_STAGES-1:0][7:0]   sync_r;
  logic [7:0]                    hist_r;
  logic [2:0]                    code_r, code_next_s;
  logic [7:0]                    fall_s, set_s, clr_s, pending_next_s;
  logic                          eo_next_s;

  function automatic logic [2:0] highest_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = i[2:0];
    end
    return idx;
  endfunction

  // A fall is synced-low with history still high; only armed lines count.
  assign fall_s = hist_r & ~sync_r[SYNC_STAGES-1];

  // Next-state, grant code and pending update.
  always_comb begin
    state_next_s = state_r;
    code_next_s  = code_r;
    clr_s        = 8'h00;
    case (state_r)
      IDLE: begin
        if (!EI_n && (pending != 8'h00)) begin
          state_next_s = PRESENT;
          code_next_s  = highest_index(pending);
        end else begin
          state_next_s = IDLE;
        end
      end
      PRESENT: begin
        if (ack) begin
          clr_s        = 8'h01 << code_r;
          state_next_s = IDLE;
        end else if (EI_n) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = PRESENT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    if (EI_n) begin
      set_s = 8'h00;
    end else begin
      set_s = fall_s;
    end
    // Set is applied after clear so a same-cycle re-request survives the ack.
    pending_next_s = (pending & ~clr_s) | set_s;
    eo_next_s      = ~(!EI_n && (pending == 8'h00) && (state_r == IDLE));
  end

  // Synchronizer, history, FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r  <= '1;
      hist_r  <= 8'hFF;
      state_r <= IDLE;
      code_r  <= 3'd0;
      pending <= 8'h00;
      A_n     <= 3'b111;
      GS_n    <= 1'b1;
      valid   <= 1'b0;
      EO_n    <= 1'b1;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], I_n};
      hist_r  <= sync_r[SYNC_STAGES-1];
      state_r <= state_next_s;
      code_r  <= code_next_s;
      pending <= pending_next_s;
      EO_n    <= eo_next_s;
      if (state_next_s == PRESENT) begin
        A_n   <= ~code_next_s;
        GS_n  <= 1'b0;
        valid <= 1'b1;
      end else begin
        A_n   <= 3'b111;
        GS_n  <= 1'b1;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_req_priority_encoder_8to3.sv
// Self-checking bench: directed scenarios plus random traffic, every edge
// compared against a cycle-level behavioural model of the encoder.
module tb_req_priority_encoder_8to3;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst, EI_n, ack;
  logic [7:0] I_n;
  logic [2:0] A_n;
  logic       GS_n, valid, EO_n;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;

  logic [7:0] cur_i;
  logic       cur_ei;

  // model state: past input samples (newest first), pending set, grant
  logic [7:0] samp_q[$];
  logic [7:0] m_pend;
  bit         m_pres;
  int         m_code;
  logic       m_eo;

  req_priority_encoder_8to3 #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .EI_n(EI_n), .I_n(I_n), .ack(ack),
    .A_n(A_n), .GS_n(GS_n), .valid(valid), .EO_n(EO_n), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int top_index(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_edge(input logic [7:0] iv, input logic ei, input logic ak, input logic rs);
    logic [7:0] synced, hist, set_m, clr_m;
    logic       nxt_eo;
    if (rs) begin
      samp_q.delete();
      for (int k = 0; k <= SS; k++) samp_q.push_front(8'hFF);
      m_pend = 8'h00;
      m_pres = 0;
      m_eo   = 1'b1;
    end else begin
      synced = samp_q[SS-1];
      hist   = samp_q[SS];
      set_m  = ei ? 8'h00 : (hist & ~synced);
      clr_m  = 8'h00;
      nxt_eo = !(ei == 1'b0 && m_pend == 8'h00 && !m_pres);
      if (m_pres) begin
        if (ak) begin
          clr_m[m_code] = 1'b1;
          m_pres = 0;
        end else if (ei) begin
          m_pres = 0;
        end
      end else if (!ei && m_pend != 8'h00) begin
        m_pres = 1;
        m_code = top_index(m_pend);
      end
      m_pend = (m_pend & ~clr_m) | set_m;
      m_eo   = nxt_eo;
      samp_q.push_front(iv);
      void'(samp_q.pop_back());
    end
  endtask

  task automatic compare_all();
    logic [2:0] ea;
    ea = m_pres ? ~m_code[2:0] : 3'b111;
    check_value("A_n",     {5'b0, A_n},   {5'b0, ea});
    check_value("GS_n",    {7'b0, GS_n},  {7'b0, !m_pres});
    check_value("valid",   {7'b0, valid}, {7'b0, m_pres});
    check_value("EO_n",    {7'b0, EO_n},  {7'b0, m_eo});
    check_value("pending", pending,       m_pend);
  endtask

  task automatic tick(input logic ak, input logic rs);
    rst = rs; I_n = cur_i; EI_n = cur_ei; ack = ak;
    @(posedge clk);
    model_edge(cur_i, cur_ei, ak, rs);
    #1;
    compare_all();
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0);
  endtask

  task automatic wait_valid(input int max_cycles);
    bool_wait: begin
      for (int k = 0; k < max_cycles; k++) begin
        if (valid) disable bool_wait;
        tick(1'b0, 1'b0);
      end
      check_value("wait_valid_timeout", {7'b0, valid}, 8'h01);
    end
  endtask

  initial begin
    cur_i = 8'hFF; cur_ei = 1'b0;
    rst = 1'b1; I_n = 8'hFF; EI_n = 1'b0; ack = 1'b0;

    // 1. reset
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check_value("rst_A_n", {5'b0, A_n}, 8'h07);
    check_value("rst_valid", {7'b0, valid}, 8'h00);
    check_value("rst_EO_n", {7'b0, EO_n}, 8'h01);
    check_value("rst_pending", pending, 8'h00);
    tick(1'b0, 1'b0);
    check_value("eo_after_rst", {7'b0, EO_n}, 8'h00);

    // 2. single request on line 5
    cur_i[5] = 1'b0;
    idle_ticks(3);
    check_value("t2_pending", pending, 8'h20);
    tick(1'b0, 1'b0);
    check_value("t2_A_n", {5'b0, A_n}, 8'h02);
    check_value("t2_GS_n", {7'b0, GS_n}, 8'h00);
    tick(1'b1, 1'b0);
    check_value("t2_ack_pend", pending, 8'h00);
    tick(1'b0, 1'b0);
    check_value("t2_EO_n", {7'b0, EO_n}, 8'h00);
    cur_i = 8'hFF; idle_ticks(4);

    // 3. priority between lines 2 and 6
    cur_i[2] = 1'b0; cur_i[6] = 1'b0;
    wait_valid(10);
    check_value("t3_first", {5'b0, A_n}, 8'h01);
    tick(1'b1, 1'b0);
    check_value("t3_gap", {7'b0, valid}, 8'h00);
    tick(1'b0, 1'b0);
    check_value("t3_second", {5'b0, A_n}, 8'h05);
    tick(1'b1, 1'b0);
    check_value("t3_pend", pending, 8'h00);
    cur_i = 8'hFF; idle_ticks(4);

    // 4. held line gives one grant only, re-arms after release
    cur_i[3] = 1'b0;
    wait_valid(10);
    tick(1'b1, 1'b0);
    idle_ticks(6);
    check_value("t4_no_regrant", {7'b0, valid}, 8'h00);
    cur_i[3] = 1'b1; idle_ticks(3);
    cur_i[3] = 1'b0;
    wait_valid(10);
    check_value("t4_regrant", {5'b0, A_n}, 8'h04);
    tick(1'b1, 1'b0);
    cur_i = 8'hFF; idle_ticks(4);

    // 5. set of bit 4 in the same cycle its grant is acked
    cur_i[4] = 1'b0;
    wait_valid(10);
    cur_i[4] = 1'b1; idle_ticks(3);
    cur_i[4] = 1'b0;
    idle_ticks(2);
    tick(1'b1, 1'b0);
    check_value("t5_set_wins", {7'b0, pending[4]}, 8'h01);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check_value("t5_regrant", {5'b0, A_n}, 8'h03);
    tick(1'b1, 1'b0);
    cur_i = 8'hFF; idle_ticks(4);

    // 6. enable and reset in the middle of a grant
    cur_i[7] = 1'b0;
    wait_valid(10);
    cur_ei = 1'b1; tick(1'b0, 1'b0);
    check_value("t6_dis_valid", {7'b0, valid}, 8'h00);
    check_value("t6_kept", {7'b0, pending[7]}, 8'h01);
    cur_i[1] = 1'b0; idle_ticks(4);
    check_value("t6_no_cap", {7'b0, pending[1]}, 8'h00);
    cur_ei = 1'b0;
    wait_valid(10);
    check_value("t6_regrant", {5'b0, A_n}, 8'h00);
    tick(1'b0, 1'b1);
    check_value("t6_rst_valid", {7'b0, valid}, 8'h00);
    check_value("t6_rst_pend", pending, 8'h00);
    check_value("t6_rst_A_n", {5'b0, A_n}, 8'h07);
    cur_i = 8'hFF; tick(1'b0, 1'b1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cur_i  = cur_i ^ ($urandom & $urandom & $urandom);
      cur_ei = ($urandom_range(0, 15) == 0);
      tick(logic'($urandom_range(0, 1)), ($urandom_range(0, 499) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
